// File: rtl/boot_rom_pkg.sv
`default_nettype none
// ============================================================================
// Package  : boot_rom_pkg
// Brief    : Boot image contents and the response type shared by the boot ROM.
// Revision : 1.0
// ============================================================================
package boot_rom_pkg;

    localparam int BOOT_IMAGE_LEN = 8;

    // Word 0 sits in the least-significant slot, so BOOT_IMAGE[n] is word n.
    localparam logic [BOOT_IMAGE_LEN-1:0][31:0] BOOT_IMAGE = {
        32'hFFDF_F06F,
        32'h1050_0073,
        32'h0000_0013,
        32'h0002_8067,
        32'h0182_B283,
        32'hF140_2573,
        32'h0202_8593,
        32'h0000_0297
    };

    localparam logic [31:0] BOOT_RESET_VEC_OFFSET = 32'h0000_0000;

    localparam int BOOT_DATA_MAX_W = 64;

    typedef struct packed {
        logic                       valid;
        logic                       err;
        logic [BOOT_DATA_MAX_W-1:0] data;
    } boot_rsp_t;

endpackage
`default_nettype wire

// File: rtl/boot_rom_patch.sv
`default_nettype none
// ============================================================================
// Module   : boot_rom_patch
// Brief    : Patch slot registers with clear/write and lowest-index-wins match.
// Revision : 1.0
// ============================================================================
module boot_rom_patch #(
    parameter int DATA_WIDTH    = 32,
    parameter int IDX_W         = 10,
    parameter int PATCH_ENTRIES = 4,
    parameter int SLOT_W        = 2
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  patch_we_i,
    input  logic                  patch_clr_i,
    input  logic [SLOT_W-1:0]     patch_idx_i,
    input  logic [IDX_W-1:0]      patch_addr_i,
    input  logic [DATA_WIDTH-1:0] patch_data_i,
    input  logic [IDX_W-1:0]      lookup_idx_i,
    output logic                  hit_o,
    output logic [DATA_WIDTH-1:0] hit_data_o
);

    logic [PATCH_ENTRIES-1:0] r_valid;
    logic [IDX_W-1:0]         r_addr [PATCH_ENTRIES];
    logic [DATA_WIDTH-1:0]    r_data [PATCH_ENTRIES];

    // The write branch wins over clear, so clear+write leaves only that slot valid.
    // Slot indices at or above PATCH_ENTRIES match no slot and are dropped.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_valid <= '0;
            for (int i = 0; i < PATCH_ENTRIES; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PATCH_ENTRIES; i++) begin
                if (patch_we_i && (patch_idx_i == SLOT_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_addr[i]  <= patch_addr_i;
                    r_data[i]  <= patch_data_i;
                end else if (patch_clr_i) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Scanning from the top down lets the lowest matching slot overwrite the result last.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int i = PATCH_ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_addr[i] == lookup_idx_i)) begin
                hit_o      = 1'b1;
                hit_data_o = r_data[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/boot_rom_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : boot_rom_ctrl
// Brief    : Boot ROM, req/gnt/rvalid port, 1 or 2 cycle latency, range error.
//            Runtime patch table present when BOOT_ROM_PATCH_EN is defined.
// Revision : 1.0
// ============================================================================
module boot_rom_ctrl
    import boot_rom_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 1024,
    parameter int ADDR_WIDTH    = 12,
    parameter int LATENCY       = 1,
    parameter int PATCH_ENTRIES = 4
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
`ifdef BOOT_ROM_PATCH_EN
    ,
    input  logic                  patch_we_i,
    input  logic                  patch_clr_i,
    input  logic [((PATCH_ENTRIES > 1) ? $clog2(PATCH_ENTRIES) : 1)-1:0] patch_idx_i,
    input  logic [ADDR_WIDTH-3:0] patch_addr_i,
    input  logic [DATA_WIDTH-1:0] patch_data_i
`endif
);

    localparam int                  c_idx_w    = $clog2(DEPTH);
    localparam int                  c_rom_size = 1 << c_idx_w;
    localparam logic [ADDR_WIDTH-2:0] c_depth  = (ADDR_WIDTH-1)'(DEPTH);

    logic                  w_req;
    logic [ADDR_WIDTH-3:0] w_word_idx;
    logic                  w_in_range;
    logic [DATA_WIDTH-1:0] w_rom [c_rom_size];
    logic [DATA_WIDTH-1:0] w_rom_data;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic                  w_unused_bits;
    boot_rsp_t             r_out;

    // Reset gates the accept path so nothing is granted while RSTN is low.
    assign w_req      = req_i & RSTN;
    assign gnt_o      = w_req;
    assign w_word_idx = addr_i[ADDR_WIDTH-1:2];
    assign w_in_range = {1'b0, w_word_idx} < c_depth;

    for (genvar gi = 0; gi < c_rom_size; gi++) begin : g_rom
        if ((gi < BOOT_IMAGE_LEN) && (gi < DEPTH)) begin : g_img
            assign w_rom[gi] = DATA_WIDTH'(BOOT_IMAGE[gi]);
        end else begin : g_zero
            assign w_rom[gi] = '0;
        end
    end

    assign w_rom_data = w_in_range ? w_rom[w_word_idx[c_idx_w-1:0]] : '0;

`ifdef BOOT_ROM_PATCH_EN
    logic w_patch_hit;

    boot_rom_patch #(
        .DATA_WIDTH    (DATA_WIDTH),
        .IDX_W         (ADDR_WIDTH - 2),
        .PATCH_ENTRIES (PATCH_ENTRIES),
        .SLOT_W        ((PATCH_ENTRIES > 1) ? $clog2(PATCH_ENTRIES) : 1)
    ) u_patch (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .patch_we_i   (patch_we_i),
        .patch_clr_i  (patch_clr_i),
        .patch_idx_i  (patch_idx_i),
        .patch_addr_i (patch_addr_i),
        .patch_data_i (patch_data_i),
        .lookup_idx_i (w_word_idx),
        .hit_o        (w_patch_hit),
        .hit_data_o   (w_hit_data)
    );

    assign w_hit = w_patch_hit & w_in_range;
`else
    logic w_unused_cfg;

    assign w_hit        = 1'b0;
    assign w_hit_data   = '0;
    assign w_unused_cfg = (PATCH_ENTRIES != 0);
`endif

    if (LATENCY == 1) begin : g_lat1
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                r_out <= '0;
            end else begin
                r_out.valid <= w_req;
                if (w_req) begin
                    r_out.err  <= ~w_in_range;
                    r_out.data <= BOOT_DATA_MAX_W'(w_hit ? w_hit_data : w_rom_data);
                end
            end
        end
    end else begin : g_lat2
        boot_rsp_t             r_s1;
        logic                  r_s1_hit;
        logic [DATA_WIDTH-1:0] r_s1_hit_data;

        // Stage 1 registers the array word and the request-cycle patch result;
        // stage 2 applies the override.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                r_s1          <= '0;
                r_s1_hit      <= 1'b0;
                r_s1_hit_data <= '0;
                r_out         <= '0;
            end else begin
                r_s1.valid <= w_req;
                if (w_req) begin
                    r_s1.err      <= ~w_in_range;
                    r_s1.data     <= BOOT_DATA_MAX_W'(w_rom_data);
                    r_s1_hit      <= w_hit;
                    r_s1_hit_data <= w_hit_data;
                end
                r_out.valid <= r_s1.valid;
                if (r_s1.valid) begin
                    r_out.err  <= r_s1.err;
                    r_out.data <= r_s1_hit ? BOOT_DATA_MAX_W'(r_s1_hit_data) : r_s1.data;
                end
            end
        end
    end

    assign rvalid_o      = r_out.valid;
    assign err_o         = r_out.err;
    assign rdata_o       = r_out.data[DATA_WIDTH-1:0];
    assign w_unused_bits = ^{addr_i[1:0], r_out.data};

endmodule
`default_nettype wire
